// File: rtl/lock_sequencer_if.sv
// Channel-side bundle for one lock sequencer: transmission sample, thresholds,
// coefficient-update handshake and the servo control / status outputs.
interface lock_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                         enable_in;
  logic signed [DATA_WIDTH-1:0] trans_in;
  logic signed [DATA_WIDTH-1:0] minval_in;
  logic signed [DATA_WIDTH-1:0] acqval_in;
  logic                         upd_req_in;
  logic                         allow_live_in;
  logic                         pid_on_out;
  logic                         sweep_hold_out;
  logic                         upd_ack_out;
  logic [1:0]                   state_out;
  logic [CNT_WIDTH-1:0]         relock_cnt_out;
  logic [2:0]                   led_out;

  // Driver side: the channel front end / parameter path feeding the sequencer
  modport master (
    output enable_in, trans_in, minval_in, acqval_in, upd_req_in, allow_live_in,
    input  pid_on_out, sweep_hold_out, upd_ack_out, state_out, relock_cnt_out, led_out
  );

  // Sequencer side
  modport slave (
    input  enable_in, trans_in, minval_in, acqval_in, upd_req_in, allow_live_in,
    output pid_on_out, sweep_hold_out, upd_ack_out, state_out, relock_cnt_out, led_out
  );
endinterface

// File: rtl/lock_sequencer.sv
// Per-channel lock controller: IDLE -> SWEEP -> SETTLE -> LOCKED sequencing from
// the transmission monitor, with a lock-loss glitch filter, a settle dwell, a
// saturating relock counter and gating of coefficient-update strobes.
module lock_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int LOSS_FILT     = 16,
  parameter int SETTLE_CYCLES = 100000000,
  parameter int CNT_WIDTH     = 16
) (
  input logic             clk_in,
  input logic             rst_n_in,
  lock_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SWEEP  = 2'b01,
    ST_SETTLE = 2'b10,
    ST_LOCKED = 2'b11
  } state_t;

  localparam logic [7:0]           LOSS_LAST   = 8'(LOSS_FILT - 1);
  localparam logic [27:0]          SETTLE_LAST = 28'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

  // Registered threshold flags: state decisions look one sample back.
  logic                 r_below;
  logic                 r_above;

  state_t               r_state;
  logic [7:0]           r_loss_cnt;
  logic [27:0]          r_settle_cnt;
  logic [CNT_WIDTH-1:0] r_relock_cnt;
  logic                 r_pending;

  logic                 r_pid_on;
  logic                 r_sweep_hold;
  logic                 r_upd_ack;
  logic [2:0]           r_led;

  state_t               w_next_state;
  logic                 w_lost;
  logic                 w_upd_ok;
  logic                 w_ack;

  // Lock is declared lost on the LOSS_FILT-th consecutive below sample.
  assign w_lost   = r_below && (r_loss_cnt == LOSS_LAST);
  // Coefficients may land while the PID is off, or live if explicitly allowed.
  assign w_upd_ok = (r_state == ST_IDLE) || (r_state == ST_SWEEP) || bus.allow_live_in;
  assign w_ack    = r_pending && w_upd_ok;

  // Input stage: compare the raw sample against both thresholds (signed).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_below <= 1'b0;
      r_above <= 1'b0;
    end else begin
      r_below <= ($signed(bus.trans_in) <  $signed(bus.minval_in));
      r_above <= ($signed(bus.trans_in) >= $signed(bus.acqval_in));
    end
  end

  // Next-state decode; enable has top priority, loss beats settle completion.
  always_comb begin
    w_next_state = r_state;
    if (!bus.enable_in) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_next_state = ST_SWEEP;
        ST_SWEEP:  begin
          if (r_above) begin
            w_next_state = ST_SETTLE;
          end else begin
            w_next_state = ST_SWEEP;
          end
        end
        ST_SETTLE: begin
          if (w_lost) begin
            w_next_state = ST_SWEEP;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            w_next_state = ST_LOCKED;
          end else begin
            w_next_state = ST_SETTLE;
          end
        end
        ST_LOCKED: begin
          if (w_lost) begin
            w_next_state = ST_SWEEP;
          end else begin
            w_next_state = ST_LOCKED;
          end
        end
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM: state, loss/settle/relock counters and outputs decoded from next state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= ST_IDLE;
      r_loss_cnt   <= 8'd0;
      r_settle_cnt <= 28'd0;
      r_relock_cnt <= {CNT_WIDTH{1'b0}};
      r_pid_on     <= 1'b0;
      r_sweep_hold <= 1'b1;
      r_led        <= 3'b010;
    end else begin
      r_state <= w_next_state;

      // Any state change restarts the glitch filter.
      if (w_next_state != r_state) begin
        r_loss_cnt <= 8'd0;
      end else if (r_below && ((r_state == ST_SETTLE) || (r_state == ST_LOCKED))) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end else begin
        r_loss_cnt <= 8'd0;
      end

      // Dwell counts only while remaining in SETTLE; entry starts it from zero.
      if ((r_state == ST_SETTLE) && (w_next_state == ST_SETTLE)) begin
        r_settle_cnt <= r_settle_cnt + 28'd1;
      end else begin
        r_settle_cnt <= 28'd0;
      end

      // Only a loss out of LOCKED is a relock event; a failed settle is not.
      if ((r_state == ST_LOCKED) && (w_next_state == ST_SWEEP) && (r_relock_cnt != CNT_MAX)) begin
        r_relock_cnt <= r_relock_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_relock_cnt <= r_relock_cnt;
      end

      case (w_next_state)
        ST_IDLE: begin
          r_pid_on     <= 1'b0;
          r_sweep_hold <= 1'b1;
          r_led        <= 3'b010;
        end
        ST_SWEEP: begin
          r_pid_on     <= 1'b0;
          r_sweep_hold <= 1'b0;
          r_led        <= 3'b010;
        end
        ST_SETTLE: begin
          r_pid_on     <= 1'b1;
          r_sweep_hold <= 1'b1;
          r_led        <= 3'b001;
        end
        ST_LOCKED: begin
          r_pid_on     <= 1'b1;
          r_sweep_hold <= 1'b1;
          r_led        <= 3'b100;
        end
        default: begin
          r_pid_on     <= 1'b0;
          r_sweep_hold <= 1'b1;
          r_led        <= 3'b010;
        end
      endcase
    end
  end

  // Update gating: a request raised on an ack edge stays pending for a second ack.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pending <= 1'b0;
      r_upd_ack <= 1'b0;
    end else begin
      r_upd_ack <= w_ack;
      r_pending <= bus.upd_req_in || (r_pending && !w_upd_ok);
    end
  end

  assign bus.pid_on_out     = r_pid_on;
  assign bus.sweep_hold_out = r_sweep_hold;
  assign bus.upd_ack_out    = r_upd_ack;
  assign bus.state_out      = r_state;
  assign bus.relock_cnt_out = r_relock_cnt;
  assign bus.led_out        = r_led;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: a vector table for the start-up and
// gating basics, hand sequences for timing corners, and randomized stimulus
// checked every cycle against a behavioural reference model.
module tb_lock_sequencer;
  localparam int DW = 16;
  localparam int LF = 16;
  localparam int SC = 1000;
  localparam int CW = 2;
  localparam int RELOCK_MAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  lock_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  lock_sequencer #(
    .DATA_WIDTH(DW), .LOSS_FILT(LF), .SETTLE_CYCLES(SC), .CNT_WIDTH(CW)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 sweeping, 2 settling, 3 locked.
  int m_mode, m_run, m_dwell, m_relock;
  bit m_pending, m_ack, prev_valid;
  logic signed [DW-1:0] prev_trans, prev_min, prev_acq;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_dwell = 0; m_relock = 0;
    m_pending = 1'b0; m_ack = 1'b0; prev_valid = 1'b0;
  endtask

  // One clock edge of the model, using inputs as the DUT saw them at that edge.
  task automatic model_step();
    bit below, above, lost, ok;
    int nm;
    below = prev_valid && (prev_trans < prev_min);
    above = prev_valid && (prev_trans >= prev_acq);
    lost  = below && (m_run + 1 >= LF);
    if (!bus.enable_in)    nm = 0;
    else if (m_mode == 0)  nm = 1;
    else if (m_mode == 1)  nm = above ? 2 : 1;
    else if (lost)         nm = 1;
    else if (m_mode == 2)  nm = (m_dwell + 1 >= SC) ? 3 : 2;
    else                   nm = 3;
    if (m_mode == 3 && nm == 1 && m_relock < RELOCK_MAX) m_relock++;
    m_run   = (nm == m_mode && below && m_mode >= 2) ? m_run + 1 : 0;
    m_dwell = (nm == 2 && m_mode == 2) ? m_dwell + 1 : 0;
    ok = (m_mode <= 1) || bus.allow_live_in;
    m_ack = m_pending && ok;
    m_pending = bus.upd_req_in || (m_pending && !ok);
    m_mode = nm;
    prev_trans = bus.trans_in; prev_min = bus.minval_in; prev_acq = bus.acqval_in;
    prev_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_state", int'(bus.state_out), m_mode);
    check("model_pid", int'(bus.pid_on_out), (m_mode >= 2) ? 1 : 0);
    check("model_hold", int'(bus.sweep_hold_out), (m_mode != 1) ? 1 : 0);
    check("model_ack", int'(bus.upd_ack_out), int'(m_ack));
    check("model_relock", int'(bus.relock_cnt_out), m_relock);
    check("model_led", int'(bus.led_out), (m_mode == 3) ? 4 : ((m_mode == 2) ? 1 : 2));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_state"}, int'(bus.state_out), 0);
    check({nm, "_pid"}, int'(bus.pid_on_out), 0);
    check({nm, "_hold"}, int'(bus.sweep_hold_out), 1);
    check({nm, "_ack"}, int'(bus.upd_ack_out), 0);
    check({nm, "_relock"}, int'(bus.relock_cnt_out), 0);
    check({nm, "_led"}, int'(bus.led_out), 2);
  endtask

  task automatic wait_state(input int s, input int maxc, input string nm);
    int n;
    n = 0;
    while (int'(bus.state_out) != s && n < maxc) begin
      tick();
      n++;
    end
    check(nm, int'(bus.state_out), s);
  endtask

  task automatic drive_n(input logic [DW-1:0] t, input int n);
    bus.trans_in = t;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic          en;
    logic [DW-1:0] trans;
    logic          req;
    logic          live;
    logic [1:0]    st;
    logic          pid;
    logic          hold;
    logic          ack;
    logic [2:0]    led;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks, seg_left, kind;
    logic [DW-1:0] seg_lo, seg_hi;

    vecs[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'b010};
    vecs[1]  = '{1'b1, 16'h4000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'b010};
    vecs[2]  = '{1'b1, 16'h4000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'b001};
    vecs[3]  = '{1'b1, 16'h4000, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'b001};
    vecs[4]  = '{1'b1, 16'h4000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'b001};
    vecs[5]  = '{1'b1, 16'h4000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 3'b001};
    vecs[6]  = '{1'b1, 16'h4000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'b001};
    vecs[7]  = '{1'b1, 16'h4000, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'b001};
    vecs[8]  = '{1'b0, 16'h4000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'b010};
    vecs[9]  = '{1'b0, 16'h4000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'b010};
    vecs[10] = '{1'b0, 16'h4000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'b010};

    // Reset held with the channel enabled.
    rst_n = 1'b0;
    bus.enable_in = 1'b1; bus.trans_in = 16'h0000;
    bus.minval_in = 16'h2000; bus.acqval_in = 16'h3000;
    bus.upd_req_in = 1'b0; bus.allow_live_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Start-up and basic gating vectors.
    for (int i = 0; i < 11; i++) begin
      bus.enable_in = vecs[i].en; bus.trans_in = vecs[i].trans;
      bus.upd_req_in = vecs[i].req; bus.allow_live_in = vecs[i].live;
      tick();
      check($sformatf("vec%0d_state", i), int'(bus.state_out), int'(vecs[i].st));
      check($sformatf("vec%0d_pid", i), int'(bus.pid_on_out), int'(vecs[i].pid));
      check($sformatf("vec%0d_hold", i), int'(bus.sweep_hold_out), int'(vecs[i].hold));
      check($sformatf("vec%0d_ack", i), int'(bus.upd_ack_out), int'(vecs[i].ack));
      check($sformatf("vec%0d_led", i), int'(bus.led_out), int'(vecs[i].led));
    end

    // Acquire and lock: LOCKED exactly SC cycles after SETTLE entry.
    bus.enable_in = 1'b1; bus.trans_in = 16'h4000;
    wait_state(2, 10, "acq_settle_entry");
    n = 0;
    while (int'(bus.state_out) != 3 && n < SC + 100) begin
      tick();
      n++;
    end
    check("lock_dwell_cycles", n, SC);
    check("lock_led", int'(bus.led_out), 4);
    check("lock_pid", int'(bus.pid_on_out), 1);

    // Glitch filter: 15 low samples are tolerated, 16 lose lock.
    drive_n(16'h1000, 15);
    for (int i = 0; i < 3; i++) begin
      drive_n(16'h4000, 1);
      check("glitch15_hold", int'(bus.state_out), 3);
    end
    drive_n(16'h1000, 16);
    check("glitch16_pre", int'(bus.state_out), 3);
    drive_n(16'h4000, 1);
    check("glitch16_sweep", int'(bus.state_out), 1);
    check("glitch16_relock", int'(bus.relock_cnt_out), 1);

    // Loss during settle at cycle ~500: back to SWEEP, no relock count.
    wait_state(2, 10, "settle2_entry");
    drive_n(16'h4000, 499);
    drive_n(16'h1000, 16);
    check("settle_loss_pre", int'(bus.state_out), 2);
    tick();
    check("settle_loss_sweep", int'(bus.state_out), 1);
    check("settle_loss_relock", int'(bus.relock_cnt_out), 1);

    // Loss coinciding with settle completion: loss wins.
    bus.trans_in = 16'h4000;
    wait_state(2, 10, "settle3_entry");
    drive_n(16'h4000, SC - 17);
    drive_n(16'h1000, 16);
    check("coincide_pre", int'(bus.state_out), 2);
    tick();
    check("coincide_sweep", int'(bus.state_out), 1);
    check("coincide_relock", int'(bus.relock_cnt_out), 1);

    // Update request while LOCKED without live permission: ack on first SWEEP edge.
    bus.trans_in = 16'h4000;
    wait_state(3, SC + 100, "gate_lock");
    bus.allow_live_in = 1'b0; bus.upd_req_in = 1'b1;
    tick();
    bus.upd_req_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gate_no_ack_locked", int'(bus.upd_ack_out), 0);
    end
    bus.trans_in = 16'h1000;
    n = 0;
    while (int'(bus.state_out) != 1 && n < 40) begin
      tick();
      check("gate_no_ack_until_sweep", int'(bus.upd_ack_out), 0);
      n++;
    end
    check("gate_reach_sweep", int'(bus.state_out), 1);
    tick();
    check("gate_ack_first_sweep", int'(bus.upd_ack_out), 1);
    tick();
    check("gate_ack_single", int'(bus.upd_ack_out), 0);

    // Live update while LOCKED: ack on the edge after the request edge.
    bus.trans_in = 16'h4000;
    wait_state(3, SC + 100, "live_lock");
    bus.allow_live_in = 1'b1; bus.upd_req_in = 1'b1;
    tick();
    check("live_ack_not_yet", int'(bus.upd_ack_out), 0);
    bus.upd_req_in = 1'b0;
    tick();
    check("live_ack", int'(bus.upd_ack_out), 1);
    tick();
    check("live_ack_done", int'(bus.upd_ack_out), 0);
    bus.allow_live_in = 1'b0;

    // Back-to-back requests in SWEEP give exactly two acks.
    bus.trans_in = 16'h1000;
    wait_state(1, 40, "b2b_sweep");
    acks = 0;
    bus.upd_req_in = 1'b1;
    tick(); acks += int'(bus.upd_ack_out);
    tick(); acks += int'(bus.upd_ack_out);
    bus.upd_req_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); acks += int'(bus.upd_ack_out);
    end
    check("b2b_ack_count", acks, 2);

    // Two more relocks (five total) saturate the 2-bit counter.
    for (int r = 0; r < 2; r++) begin
      bus.trans_in = 16'h4000;
      wait_state(3, SC + 100, "sat_lock");
      bus.trans_in = 16'h1000;
      wait_state(1, 40, "sat_loss");
    end
    check("sat_relock", int'(bus.relock_cnt_out), 3);

    // Disable while LOCKED: IDLE next edge, counter held.
    bus.trans_in = 16'h4000;
    wait_state(3, SC + 100, "dis_lock");
    bus.enable_in = 1'b0;
    tick();
    check("dis_state", int'(bus.state_out), 0);
    check("dis_pid", int'(bus.pid_on_out), 0);
    check("dis_hold", int'(bus.sweep_hold_out), 1);
    check("dis_relock", int'(bus.relock_cnt_out), 3);

    // Mid-operation reset drops the pending request and clears counters.
    bus.enable_in = 1'b1;
    wait_state(3, SC + 100, "mid_lock");
    bus.upd_req_in = 1'b1;
    tick();
    bus.upd_req_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Randomized segments against the reference model.
    seg_left = 0; seg_lo = 16'h0000; seg_hi = 16'h0000;
    for (int c = 0; c < 8000; c++) begin
      if (seg_left == 0) begin
        kind = $urandom_range(0, 9);
        if (c >= 6000) begin
          bus.minval_in = 16'($urandom_range(0, 16'hFFFF));
          bus.acqval_in = 16'($urandom_range(0, 16'hFFFF));
        end
        if (kind <= 5) begin
          seg_lo = 16'h3000; seg_hi = 16'h7FFF; seg_left = $urandom_range(50, 1200);
        end else if (kind <= 7) begin
          seg_lo = 16'h0000; seg_hi = 16'h1FFF; seg_left = $urandom_range(1, 24);
        end else if (kind == 8) begin
          seg_lo = 16'h2000; seg_hi = 16'h2FFF; seg_left = $urandom_range(1, 40);
        end else begin
          seg_lo = 16'h0000; seg_hi = 16'hFFFF; seg_left = $urandom_range(1, 20);
        end
      end
      seg_left--;
      bus.trans_in = 16'($urandom_range(int'(seg_lo), int'(seg_hi)));
      bus.upd_req_in = ($urandom_range(0, 7) == 0);
      bus.allow_live_in = ($urandom_range(0, 3) == 0);
      bus.enable_in = ($urandom_range(0, 799) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
